// File: rtl/dig_ctrl_spi_pkg.sv
// Framing constants and FSM state encoding shared by both ends of the dig_ctrl SPI link.
package dig_ctrl_spi_pkg;

    localparam int unsigned FRAME_W  = 16;
    localparam int unsigned RW_BIT   = 15;
    localparam int unsigned ADDR_MSB = 14;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_reg_master_tick.sv
// Loadable SCLK half-period counter: tick_c is high in the CLK_DIV-th cycle after a load or a previous tick.
module spi_reg_master_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick_c
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == '0);

    // Count down to zero, restarting on an explicit load or after each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (load || tick_c) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator issuing single write/read register frames to the dig_ctrl target.
module spi_reg_master
    import dig_ctrl_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              spi_cs_o,
    output logic              spi_sclk_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i
);

    localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int unsigned BIT_W     = $clog2(FRAME_LEN);

    spi_state_t state;
    spi_state_t state_next;

    logic                 tick_c;
    logic                 load_c;
    logic [FRAME_LEN-1:0] frame_c;

    // tx holds the bits still to be presented after the current MOSI bit.
    logic [FRAME_LEN-2:0] tx;
    logic [FRAME_LEN-2:0] tx_d;
    // Only the last DATA_W sampled bits survive; command-phase MISO shifts out.
    logic [DATA_W-1:0]    rx;
    logic [DATA_W-1:0]    rx_d;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_d;
    logic                 wr;
    logic                 wr_d;

    logic                 cs_d;
    logic                 sclk_d;
    logic                 mosi_d;
    logic                 ready_d;
    logic                 done_d;
    logic [DATA_W-1:0]    rdata_d;

    // Read frames carry zero in the data field.
    assign frame_c = {write_i, addr_i, (write_i ? wdata_i : DATA_W'(0))};

    spi_reg_master_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_c),
        .tick_c (tick_c)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-value logic for all registered outputs and datapath.
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        cs_d       = spi_cs_o;
        sclk_d     = spi_sclk_o;
        mosi_d     = spi_mosi_o;
        ready_d    = ready_o;
        done_d     = 1'b0;
        rdata_d    = rdata_o;
        tx_d       = tx;
        rx_d       = rx;
        bit_d      = bit_cnt;
        wr_d       = wr;

        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = SETUP;
                    load_c     = 1'b1;
                    ready_d    = 1'b0;
                    cs_d       = 1'b0;
                    sclk_d     = 1'b0;
                    mosi_d     = frame_c[FRAME_LEN-1];
                    tx_d       = frame_c[FRAME_LEN-2:0];
                    bit_d      = '0;
                    wr_d       = write_i;
                end
            end
            SETUP: begin
                if (tick_c) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (tick_c) begin
                    sclk_d = ~spi_sclk_o;
                    if (!spi_sclk_o) begin
                        rx_d = {rx[DATA_W-2:0], spi_miso_i};
                    end else begin
                        mosi_d = tx[FRAME_LEN-2];
                        tx_d   = {tx[FRAME_LEN-3:0], 1'b0};
                        bit_d  = bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(FRAME_LEN - 1)) begin
                            state_next = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick_c) begin
                    state_next = GAP;
                    cs_d       = 1'b1;
                    done_d     = 1'b1;
                    mosi_d     = 1'b0;
                    if (!wr) begin
                        rdata_d = rx;
                    end
                end
            end
            GAP: begin
                if (tick_c) begin
                    state_next = IDLE;
                    ready_d    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs and datapath; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_cs_o   <= 1'b1;
            spi_sclk_o <= 1'b0;
            spi_mosi_o <= 1'b0;
            ready_o    <= 1'b1;
            done_o     <= 1'b0;
            rdata_o    <= '0;
            tx         <= '0;
            rx         <= '0;
            bit_cnt    <= '0;
            wr         <= 1'b0;
        end else begin
            spi_cs_o   <= cs_d;
            spi_sclk_o <= sclk_d;
            spi_mosi_o <= mosi_d;
            ready_o    <= ready_d;
            done_o     <= done_d;
            rdata_o    <= rdata_d;
            tx         <= tx_d;
            rx         <= rx_d;
            bit_cnt    <= bit_d;
            wr         <= wr_d;
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// Scoreboard bench: two spi_reg_master instances (CLK_DIV=4 and CLK_DIV=1) with an SPI target model each.
module tb_spi_reg_master;
    import dig_ctrl_spi_pkg::*;

    typedef struct packed {
        logic [FRAME_W-1:0] frame;
        logic [7:0]         rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n     [2];
    logic               start     [2];
    logic               write     [2];
    logic [6:0]         addr      [2];
    logic [7:0]         wdata     [2];
    logic               ready     [2];
    logic               done      [2];
    logic [7:0]         rdata     [2];
    logic               cs        [2];
    logic               sclk      [2];
    logic               mosi      [2];
    logic [FRAME_W-1:0] miso_word [2];

    int n_checks = 0;
    int n_fails  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Per-instance DUT, SPI target model and scoreboard monitor.
    for (genvar i = 0; i < 2; i++) begin : g_dut
        localparam int unsigned D = (i == 0) ? 4 : 1;

        logic               miso = 1'b0;
        exp_t               q[$];
        exp_t               e;
        int                 cs_cnt = 0;
        int                 hi_cnt = 0;
        int                 rises  = 0;
        int                 dones  = 0;
        logic               prev_cs   = 1'b1;
        logic               prev_sclk = 1'b0;
        logic               prev_done = 1'b0;
        logic [FRAME_W-1:0] cap = '0;
        logic [FRAME_W-1:0] msh = '0;

        spi_reg_master #(
            .CLK_DIV(D),
            .ADDR_W (7),
            .DATA_W (8)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[i]),
            .start_i    (start[i]),
            .write_i    (write[i]),
            .addr_i     (addr[i]),
            .wdata_i    (wdata[i]),
            .ready_o    (ready[i]),
            .done_o     (done[i]),
            .rdata_o    (rdata[i]),
            .spi_cs_o   (cs[i]),
            .spi_sclk_o (sclk[i]),
            .spi_mosi_o (mosi[i]),
            .spi_miso_i (miso)
        );

        // Target model and monitor, sampled on the falling clk edge.
        always @(negedge clk) begin
            if (!rst_n[i]) begin
                cs_cnt = 0;
                hi_cnt = 0;
                rises  = 0;
                miso   = 1'b0;
            end else begin
                if (prev_cs && !cs[i]) begin
                    msh    = miso_word[i];
                    cap    = '0;
                    rises  = 0;
                    cs_cnt = 0;
                    hi_cnt = 0;
                end else if (prev_sclk && !sclk[i]) begin
                    msh = {msh[FRAME_W-2:0], 1'b0};
                end
                miso = msh[FRAME_W-1];
                if (!prev_sclk && sclk[i]) begin
                    cap = {cap[FRAME_W-2:0], mosi[i]};
                    rises++;
                end
                if (!cs[i]) cs_cnt++;
                if (sclk[i]) hi_cnt++;
                if (done[i]) begin
                    dones++;
                    check($sformatf("dut%0d_done_width", i), 32'(prev_done), 32'd0);
                    if (q.size() == 0) begin
                        check($sformatf("dut%0d_unexpected_done", i), 32'(q.size()), 32'd1);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("dut%0d_mosi_rw", i), 32'(cap[RW_BIT]), 32'(e.frame[RW_BIT]));
                        check($sformatf("dut%0d_mosi_addr", i), 32'(cap[ADDR_MSB:ADDR_LSB]),
                              32'(e.frame[ADDR_MSB:ADDR_LSB]));
                        check($sformatf("dut%0d_mosi_data", i), 32'(cap[DATA_MSB:DATA_LSB]),
                              32'(e.frame[DATA_MSB:DATA_LSB]));
                        check($sformatf("dut%0d_rdata", i), 32'(rdata[i]), 32'(e.rdata));
                        check($sformatf("dut%0d_cs_low_cycles", i), 32'(cs_cnt), 32'(34 * D));
                        check($sformatf("dut%0d_sclk_rises", i), 32'(rises), 32'd16);
                        check($sformatf("dut%0d_sclk_high_cycles", i), 32'(hi_cnt), 32'(16 * D));
                        check($sformatf("dut%0d_cs_at_done", i), 32'(cs[i]), 32'd1);
                    end
                end
            end
            prev_cs   = cs[i];
            prev_sclk = sclk[i];
            prev_done = done[i];
        end
    end

    function automatic void push_exp(input int k, input logic [FRAME_W-1:0] f, input logic [7:0] r);
        exp_t x;
        x.frame = f;
        x.rdata = r;
        if (k == 0) g_dut[0].q.push_back(x);
        else        g_dut[1].q.push_back(x);
    endfunction

    task automatic wait_ready(input int k, input int limit, output int n);
        n = 0;
        while (!ready[k] && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!ready[k]) check("ready_timeout", 32'(ready[k]), 32'd1);
    endtask

    task automatic wait_done(input int k, input int limit);
        int n;
        n = 0;
        while (!done[k] && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done[k]) check("done_timeout", 32'(done[k]), 32'd1);
    endtask

    // Issue one command on a negedge with ready high; returns one cycle after the start cycle.
    task automatic issue(input int k, input logic w, input logic [6:0] a, input logic [7:0] d,
                         input logic [FRAME_W-1:0] mw, input logic [FRAME_W-1:0] ef,
                         input logic [7:0] er, input bit push);
        int n;
        wait_ready(k, 400, n);
        miso_word[k] = mw;
        start[k]     = 1'b1;
        write[k]     = w;
        addr[k]      = a;
        wdata[k]     = d;
        if (push) push_exp(k, ef, er);
        @(negedge clk);
        start[k] = 1'b0;
        write[k] = 1'($urandom);
        addr[k]  = 7'($urandom);
        wdata[k] = 8'($urandom);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            rst_n[k]     = 1'b0;
            start[k]     = 1'b0;
            write[k]     = 1'b0;
            addr[k]      = '0;
            wdata[k]     = '0;
            miso_word[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_cs", 32'(cs[k]), 32'd1);
            check("reset_sclk", 32'(sclk[k]), 32'd0);
            check("reset_mosi", 32'(mosi[k]), 32'd0);
            check("reset_ready", 32'(ready[k]), 32'd1);
            check("reset_done", 32'(done[k]), 32'd0);
            check("reset_rdata", 32'(rdata[k]), 32'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        // Write 0x05 <- 0xA5, then start-to-ready period.
        issue(0, 1'b1, 7'h05, 8'hA5, 16'h0000, 16'h85A5, 8'h00, 1'b1);
        wait_ready(0, 400, n);
        check("start_to_ready_div4", 32'(n + 1), 32'd141);

        // Read 0x12; command-phase MISO is all ones and must be discarded.
        issue(0, 1'b0, 7'h12, 8'h77, 16'hFF3C, 16'h1200, 8'h3C, 1'b1);
        wait_ready(0, 400, n);
        check("rdata_held", 32'(rdata[0]), 32'h3C);

        // Second start 10 cycles into a frame is ignored.
        issue(0, 1'b1, 7'h33, 8'h5A, 16'h0000, 16'hB35A, 8'h3C, 1'b1);
        repeat (9) @(negedge clk);
        start[0] = 1'b1;
        write[0] = 1'b0;
        addr[0]  = 7'h7F;
        @(negedge clk);
        start[0] = 1'b0;
        check("busy_ready_low", 32'(ready[0]), 32'd0);
        wait_ready(0, 400, n);

        // Back-to-back: start held high from the done cycle onward.
        issue(0, 1'b1, 7'h01, 8'h0F, 16'h0000, 16'h810F, 8'h3C, 1'b1);
        wait_done(0, 400);
        start[0]     = 1'b1;
        write[0]     = 1'b0;
        addr[0]      = 7'h40;
        wdata[0]     = 8'hEE;
        miso_word[0] = 16'h00C3;
        push_exp(0, 16'h4000, 8'hC3);
        n = 0;
        while (!ready[0] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("gap_cycles", 32'(n), 32'd4);
        @(negedge clk);
        start[0] = 1'b0;
        check("b2b_cs_low", 32'(cs[0]), 32'd0);
        check("b2b_ready_low", 32'(ready[0]), 32'd0);
        wait_ready(0, 400, n);
        check("b2b_rdata", 32'(rdata[0]), 32'hC3);

        // Reset 50 cycles into a read aborts it immediately.
        issue(0, 1'b0, 7'h22, 8'h00, 16'hAAAA, 16'h0000, 8'h00, 1'b0);
        repeat (49) @(negedge clk);
        check("abort_cs_before", 32'(cs[0]), 32'd0);
        rst_n[0] = 1'b0;
        #1;
        check("abort_cs", 32'(cs[0]), 32'd1);
        check("abort_sclk", 32'(sclk[0]), 32'd0);
        check("abort_ready", 32'(ready[0]), 32'd1);
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_rdata", 32'(rdata[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        issue(0, 1'b1, 7'h7E, 8'h81, 16'h0000, 16'hFE81, 8'h00, 1'b1);
        wait_ready(0, 400, n);

        // CLK_DIV=1 instance.
        issue(1, 1'b1, 7'h7F, 8'hFF, 16'h0000, 16'hFFFF, 8'h00, 1'b1);
        wait_ready(1, 100, n);
        check("start_to_ready_div1", 32'(n + 1), 32'd36);
        issue(1, 1'b0, 7'h00, 8'h55, 16'h0081, 16'h0000, 8'h81, 1'b1);
        wait_ready(1, 100, n);

        repeat (5) @(negedge clk);
        check("dut0_done_count", 32'(g_dut[0].dones), 32'd6);
        check("dut1_done_count", 32'(g_dut[1].dones), 32'd2);
        check("dut0_queue_empty", 32'(g_dut[0].q.size()), 32'd0);
        check("dut1_queue_empty", 32'(g_dut[1].q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
